// File: rtl/mem_copy_engine_pkg.sv
// Shared definitions for the memory copy engine: FSM state encoding and default widths.
package mem_copy_defs;

    localparam int unsigned DEF_DW = 16;
    localparam int unsigned DEF_AW = 16;
    localparam int unsigned DEF_LW = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        FIN  = 2'd3
    } state_e;

endpackage

// File: rtl/mem_copy_engine_ptr.sv
// Loadable address pointer with increment; wraps modulo 2^AW.
module mem_copy_ptr #(
    parameter int unsigned AW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic [AW-1:0] load_val_i,
    input  logic          inc_i,
    output logic [AW-1:0] ptr_o
);

    logic [AW-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (load_i) begin
            ptr_d = load_val_i;
        end else if (inc_i) begin
            ptr_d = ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/mem_copy_engine.sv
// DMA-style word copier for DataMemory: one read then one write per word.
// Optional MEM_COPY_CHECKSUM_EN adds a running sum of all written words.
module mem_copy_engine
    import mem_copy_defs::*;
#(
    parameter int unsigned DW = DEF_DW,
    parameter int unsigned AW = DEF_AW,
    parameter int unsigned LW = DEF_LW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [LW-1:0] length,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          aborted,
    output logic [LW-1:0] words_done,
    output logic          MemRead,
    output logic          MemWrite,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
`ifdef MEM_COPY_CHECKSUM_EN
    ,
    output logic [DW-1:0] checksum
`endif
);

    state_e        state_q, state_d;
    logic [DW-1:0] data_q, data_d;
    logic [LW-1:0] words_q, words_d;
    logic [LW-1:0] len_q, len_d;
    logic          aborted_q, aborted_d;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [LW-1:0] words_inc;
    logic          src_load, src_inc, dst_load, dst_inc;
    logic [AW-1:0] src_ptr, dst_ptr;

    mem_copy_ptr #(.AW(AW)) u_src_ptr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (src_load),
        .load_val_i (src_addr),
        .inc_i      (src_inc),
        .ptr_o      (src_ptr)
    );

    mem_copy_ptr #(.AW(AW)) u_dst_ptr (
        .clk        (clk),
        .rst        (rst),
        .load_i     (dst_load),
        .load_val_i (dst_addr),
        .inc_i      (dst_inc),
        .ptr_o      (dst_ptr)
    );

    assign words_inc = words_q + LW'(1);

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        words_d   = words_q;
        len_d     = len_q;
        aborted_d = aborted_q;
        src_load  = 1'b0;
        src_inc   = 1'b0;
        dst_load  = 1'b0;
        dst_inc   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d     = length;
                    words_d   = '0;
                    aborted_d = 1'b0;
                    src_load  = 1'b1;
                    dst_load  = 1'b1;
                    state_d   = (length != '0) ? RD : FIN;
                end
            end
            RD: begin
                data_d  = mem_rdata;
                src_inc = 1'b1;
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = FIN;
                end else begin
                    state_d = WR;
                end
            end
            WR: begin
                // The write in this cycle commits even when aborting, so it is counted.
                dst_inc = 1'b1;
                words_d = words_inc;
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = FIN;
                end else if (words_inc < len_q) begin
                    state_d = RD;
                end else begin
                    state_d = FIN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy       = (state_q != IDLE);
    assign done       = (state_q == FIN);
    assign MemRead    = (state_q == RD);
    assign MemWrite   = (state_q == WR);
    assign aborted    = aborted_q;
    assign words_done = words_q;
    // Address/data are live during accesses and otherwise replay the last driven value.
    assign mem_addr   = MemRead ? src_ptr : (MemWrite ? dst_ptr : addr_q);
    assign mem_wdata  = MemWrite ? data_q : wdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            data_q    <= '0;
            words_q   <= '0;
            len_q     <= '0;
            aborted_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            words_q   <= words_d;
            len_q     <= len_d;
            aborted_q <= aborted_d;
            addr_q    <= mem_addr;
            wdata_q   <= mem_wdata;
        end
    end

`ifdef MEM_COPY_CHECKSUM_EN
    logic [DW-1:0] cks_q, cks_d;

    always_comb begin
        cks_d = cks_q;
        if (state_q == IDLE && start) begin
            cks_d = '0;
        end else if (state_q == WR) begin
            cks_d = cks_q + data_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cks_q <= '0;
        end else begin
            cks_q <= cks_d;
        end
    end

    assign checksum = cks_q;
`else
    // No accumulator in this build; copy behaviour is unchanged.
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// Self-checking bench for mem_copy_engine with a behavioural DataMemory behind the port.
// Checks the checksum output as well when MEM_COPY_CHECKSUM_EN is defined.
module tb_mem_copy_engine;
    import mem_copy_defs::*;

    localparam int unsigned DW = DEF_DW;
    localparam int unsigned AW = DEF_AW;
    localparam int unsigned LW = DEF_LW;

    logic          clk;
    logic          rst;
    logic          start;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic [LW-1:0] length;
    logic          abort;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [LW-1:0] words_done;
    logic          MemRead;
    logic          MemWrite;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
`ifdef MEM_COPY_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    mem_copy_engine #(.DW(DW), .AW(AW), .LW(LW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .length     (length),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted),
        .words_done (words_done),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
`ifdef MEM_COPY_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // DataMemory model: combinational read, write on rising edge; bench pokes when idle.
    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];
    logic        tb_we;
    logic [15:0] tb_waddr, tb_wdata;

    assign mem_rdata = MemRead ? mem[mem_addr] : 16'h0000;

    always @(posedge clk) begin
        if (MemWrite) mem[mem_addr] <= mem_wdata;
        else if (tb_we) mem[tb_waddr] <= tb_wdata;
    end

    int both_cnt = 0;
    always @(negedge clk) begin
        if (MemRead && MemWrite) both_cnt++;
    end

    int tests  = 0;
    int failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic poke(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
        ref_mem[a] = d;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic apply_model(input logic [15:0] s, input logic [15:0] d, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            ref_mem[d + 16'(i)] = ref_mem[s + 16'(i)];
        end
    endtask

    task automatic check_data(input string name, input logic [15:0] d, input int unsigned n);
        int bad;
        bad = 0;
        for (int unsigned i = 0; i < n; i++) begin
            if (mem[d + 16'(i)] !== ref_mem[d + 16'(i)]) bad++;
        end
        check(name, bad, 0);
    endtask

    // Issues one start and waits for done; counts cycles and strobes seen.
    task automatic run_copy(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                            input int abort_wr, input bit ghost,
                            output int cyc, output int nrd, output int nwr);
        int wr_seen;
        @(negedge clk);
        src_addr = s; dst_addr = d; length = l; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; nrd = 0; nwr = 0; wr_seen = 0;
        while (!done && cyc < 200) begin
            if (MemRead) nrd++;
            if (MemWrite) begin nwr++; wr_seen++; end
            abort = (abort_wr != 0) && MemWrite && (wr_seen == abort_wr);
            if (ghost && cyc == 2) begin
                start = 1'b1; src_addr = 16'h0BAD; dst_addr = 16'h0BAD; length = 16'h0001;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        abort = 1'b0;
        start = 1'b0;
        check("done_reached", {31'd0, done}, 32'd1);
    endtask

    typedef struct {
        logic [15:0] src;
        logic [15:0] dst;
        logic [15:0] len;
        int          exp_cyc;
    } job_t;

    job_t jobs [5];
    int   cyc, nrd, nwr;

    initial begin
        jobs[0] = '{16'h0002, 16'h000A, 16'h0003, 7};
        jobs[1] = '{16'h0064, 16'h0000, 16'h0000, 1};
        jobs[2] = '{16'hFFFF, 16'h0020, 16'h0002, 5};
        jobs[3] = '{16'h0028, 16'h0029, 16'h0004, 9};
        jobs[4] = '{16'h00C8, 16'h012C, 16'h0005, 11};

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        src_addr = '0; dst_addr = '0; length = '0;
        tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_busy",     {31'd0, busy},     32'd0);
        check("rst_done",     {31'd0, done},     32'd0);
        check("rst_aborted",  {31'd0, aborted},  32'd0);
        check("rst_memread",  {31'd0, MemRead},  32'd0);
        check("rst_memwrite", {31'd0, MemWrite}, 32'd0);
        check("rst_addr",     {16'd0, mem_addr},   32'd0);
        check("rst_wdata",    {16'd0, mem_wdata},  32'd0);
        check("rst_words",    {16'd0, words_done}, 32'd0);
`ifdef MEM_COPY_CHECKSUM_EN
        check("rst_checksum", {16'd0, checksum}, 32'd0);
`endif
        rst = 1'b0;

        poke(16'h0002, 16'hABCD); poke(16'h0003, 16'h1234); poke(16'h0004, 16'h0F0F);
        poke(16'hFFFF, 16'hAAAA); poke(16'h0000, 16'h5555);
        for (int unsigned i = 0; i < 5; i++) begin
            poke(16'h0028 + 16'(i), 16'h1100 + 16'(i));
            poke(16'h00C8 + 16'(i), 16'h7700 + 16'(i * 3));
        end
        for (int unsigned i = 0; i < 8; i++) poke(16'h0190 + 16'(i), 16'hDEAD);

        for (int j = 0; j < 5; j++) begin
            run_copy(jobs[j].src, jobs[j].dst, jobs[j].len, 0, 1'b0, cyc, nrd, nwr);
            apply_model(jobs[j].src, jobs[j].dst, int'(jobs[j].len));
            check($sformatf("job%0d_cycles", j), cyc, jobs[j].exp_cyc);
            check($sformatf("job%0d_words", j), {16'd0, words_done}, {16'd0, jobs[j].len});
            check($sformatf("job%0d_aborted", j), {31'd0, aborted}, 32'd0);
            check($sformatf("job%0d_reads", j), nrd, {16'd0, jobs[j].len});
            check($sformatf("job%0d_writes", j), nwr, {16'd0, jobs[j].len});
            check_data($sformatf("job%0d_data", j), jobs[j].dst, int'(jobs[j].len));
`ifdef MEM_COPY_CHECKSUM_EN
            if (j == 0) check("job0_checksum", {16'd0, checksum},
                              {16'd0, 16'(16'hABCD + 16'h1234 + 16'h0F0F)});
`endif
            @(negedge clk);
            check($sformatf("job%0d_done_pulse", j), {31'd0, done}, 32'd0);
            check($sformatf("job%0d_idle", j), {31'd0, busy}, 32'd0);
            if (j == 0) begin
                check("hold_addr",  {16'd0, mem_addr},  32'h0000_000C);
                check("hold_wdata", {16'd0, mem_wdata}, 32'h0000_0F0F);
            end
        end

        check("t1_mem10", {16'd0, mem[10]}, 32'h0000_ABCD);
        check("t1_mem11", {16'd0, mem[11]}, 32'h0000_1234);
        check("t1_mem12", {16'd0, mem[12]}, 32'h0000_0F0F);
        check("t2_mem0_untouched", {16'd0, mem[0]}, 32'h0000_5555);
        check("t3_mem20", {16'd0, mem[16'h20]}, 32'h0000_AAAA);
        check("t3_mem21", {16'd0, mem[16'h21]}, 32'h0000_5555);
        check("ovl_mem2c", {16'd0, mem[16'h2C]}, 32'h0000_1100);

        // Abort in the third WR cycle with start pulses during busy.
        run_copy(16'h00C8, 16'h0190, 16'h0008, 3, 1'b1, cyc, nrd, nwr);
        apply_model(16'h00C8, 16'h0190, 3);
        check("abort_cycles",  cyc, 7);
        check("abort_flag",    {31'd0, aborted}, 32'd1);
        check("abort_words",   {16'd0, words_done}, 32'd3);
        check("abort_writes",  nwr, 3);
        check_data("abort_data", 16'h0190, 8);
        check("ghost_addr", {16'd0, mem[16'h0BAD]}, 32'd0);
        @(negedge clk);
        check("abort_idle", {31'd0, busy}, 32'd0);
        check("aborted_holds", {31'd0, aborted}, 32'd1);
        check("words_hold", {16'd0, words_done}, 32'd3);

        run_copy(16'h0002, 16'h0030, 16'h0001, 0, 1'b0, cyc, nrd, nwr);
        apply_model(16'h0002, 16'h0030, 1);
        check("aborted_cleared", {31'd0, aborted}, 32'd0);
        check_data("single_data", 16'h0030, 1);

        // Reset asserted while in RD.
        @(negedge clk);
        src_addr = 16'h00C8; dst_addr = 16'h01F4; length = 16'h0004; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_rd", {31'd0, MemRead}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_mid_rd",   {31'd0, MemRead},  32'd0);
        check("rst_mid_wr",   {31'd0, MemWrite}, 32'd0);
        check("rst_mid_busy", {31'd0, busy},     32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_copy(16'h00C8, 16'h01F4, 16'h0004, 0, 1'b0, cyc, nrd, nwr);
        apply_model(16'h00C8, 16'h01F4, 4);
        check("post_rst_cycles", cyc, 9);
        check("post_rst_words", {16'd0, words_done}, 32'd4);
        check_data("post_rst_data", 16'h01F4, 4);

        check("strobe_exclusive", both_cnt, 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
